intarb: RTL and testbench

Processor-side Unibus interrupt arbiter and vector receiver: the responder for per-level device interrupt requesters. It samples BR4–BR7 against the current processor priority and drives the matching active-low bus grant. It accepts SACK, then receives the INTR vector from the data lines and answers it with SSYN. The accepted vector and level are handed to the CPU sequencer through a valid/ack pair.

---
 rtl/intarb_pkg.sv | 21 ++
 rtl/intarb_if.sv | 22 ++
 rtl/intarb_prio.sv | 30 +++
 rtl/intarb.sv | 174 +++++++++++++++++
 tb/tb_intarb.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intarb_pkg.sv
// intarb_pkg: shared state encoding and constants for the Unibus interrupt arbiter.
package intarb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_WAITINT,
      ST_LATCH,
      ST_SSYN,
      ST_HOLD
   } state_t;

   localparam int         BR_BASE  = 4;
   localparam logic [7:0] VEC_MASK = 8'hFC;

   // Map a 2-bit request index (0..3) onto its bus level (4..7).
   function automatic logic [2:0] level_of(input logic [1:0] idx);
      return 3'(idx) + 3'(BR_BASE);
   endfunction

endpackage

// File: rtl/intarb_if.sv
// intarb_if: Unibus request/grant/vector lines between the arbiter and its devices.
interface intarb_if;

   logic [3:0]  br_in_h;
   logic        sack_in_h;
   logic        bbsy_in_h;
   logic        intr_in_h;
   logic [15:0] d_in_h;
   logic [3:0]  bg_out_l;
   logic        ssyn_out_h;

   modport master (
      input  br_in_h, sack_in_h, bbsy_in_h, intr_in_h, d_in_h,
      output bg_out_l, ssyn_out_h
   );

   modport slave (
      output br_in_h, sack_in_h, bbsy_in_h, intr_in_h, d_in_h,
      input  bg_out_l, ssyn_out_h
   );

endinterface

// File: rtl/intarb_prio.sv
// intarb_prio: picks the highest BR level whose bus level exceeds the processor priority.
module intarb_prio
   import intarb_pkg::*;
(
   input  logic [3:0] br,
   input  logic [2:0] cpu_pri,
   output logic       pick_valid,
   output logic [1:0] pick_idx
);

   logic [3:0] eligible;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_elig
         assign eligible[gi] = br[gi] && (level_of(2'(gi)) > cpu_pri);
      end
   endgenerate

   // Ascending scan, last hit wins, so the highest eligible level is kept.
   always_comb begin
      pick_valid = |eligible;
      pick_idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (eligible[i]) begin
            pick_idx = 2'(i);
         end
      end
   end

endmodule

// File: rtl/intarb.sv
// intarb: Unibus processor-side interrupt arbiter and vector receiver.
// Optional grant timeout is built when INTARB_TIMEOUT_EN is defined.
module intarb
   import intarb_pkg::*;
#(
   parameter int DESKEW  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       init_in_h,
   input  logic [2:0] cpu_pri,
   input  logic       cpu_rdy,
   intarb_if.master   bus,
   output logic       vec_valid,
   output logic [7:0] vec_out,
   output logic [2:0] vec_level,
   input  logic       vec_ack
);

   state_t      state_reg, state_next;
   logic [3:0]  br_reg;
   logic [1:0]  lvl_reg, lvl_next;
   logic [3:0]  bg_reg, bg_next;
   logic        ssyn_reg, ssyn_next;
   logic        valid_reg, valid_next;
   logic [7:0]  vec_reg, vec_next;
   logic [2:0]  level_reg, level_next;
   logic [3:0]  dcnt_reg, dcnt_next;
`ifdef INTARB_TIMEOUT_EN
   logic [9:0]  tcnt_reg, tcnt_next;
`endif
   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic        clear;
   logic        bus_active;
   logic        unused_bits;

   assign clear       = !RESET || init_in_h;
   assign bus_active  = bus.intr_in_h && bus.bbsy_in_h;
   assign unused_bits = ^{bus.d_in_h[15:8], bus.d_in_h[1:0], 10'(TIMEOUT)};

   intarb_prio u_prio (
      .br         (br_reg),
      .cpu_pri    (cpu_pri),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
   );

   always_ff @(posedge CLOCK) begin
      if (clear) begin
         state_reg <= ST_IDLE;
         br_reg    <= 4'b0000;
         lvl_reg   <= 2'd0;
         bg_reg    <= 4'b1111;
         ssyn_reg  <= 1'b0;
         valid_reg <= 1'b0;
         vec_reg   <= 8'h00;
         level_reg <= 3'd0;
         dcnt_reg  <= 4'd0;
`ifdef INTARB_TIMEOUT_EN
         tcnt_reg  <= 10'd0;
`endif
      end else begin
         state_reg <= state_next;
         br_reg    <= bus.br_in_h;
         lvl_reg   <= lvl_next;
         bg_reg    <= bg_next;
         ssyn_reg  <= ssyn_next;
         valid_reg <= valid_next;
         vec_reg   <= vec_next;
         level_reg <= level_next;
         dcnt_reg  <= dcnt_next;
`ifdef INTARB_TIMEOUT_EN
         tcnt_reg  <= tcnt_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      lvl_next   = lvl_reg;
      bg_next    = bg_reg;
      ssyn_next  = ssyn_reg;
      valid_next = valid_reg;
      vec_next   = vec_reg;
      level_next = level_reg;
      dcnt_next  = dcnt_reg;
`ifdef INTARB_TIMEOUT_EN
      tcnt_next  = tcnt_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (cpu_rdy && pick_valid) begin
               lvl_next   = pick_idx;
               bg_next    = ~(4'b0001 << pick_idx);
               state_next = ST_GRANT;
`ifdef INTARB_TIMEOUT_EN
               tcnt_next  = 10'd0;
`endif
            end
         end

         // SACK is tested first so it wins over a simultaneous BR drop.
         ST_GRANT: begin
            if (bus.sack_in_h) begin
               bg_next    = 4'b1111;
               state_next = ST_WAITINT;
            end else if (!br_reg[lvl_reg]) begin
               bg_next    = 4'b1111;
               state_next = ST_IDLE;
            end
`ifdef INTARB_TIMEOUT_EN
            else if (tcnt_reg == 10'(TIMEOUT - 1)) begin
               bg_next    = 4'b1111;
               state_next = ST_IDLE;
            end else begin
               tcnt_next  = tcnt_reg + 10'd1;
            end
`endif
         end

         ST_WAITINT: begin
            if (bus_active) begin
               dcnt_next  = 4'd0;
               state_next = ST_LATCH;
            end else if (!bus.sack_in_h && !bus.bbsy_in_h && !bus.intr_in_h) begin
               state_next = ST_IDLE;
            end
         end

         ST_LATCH: begin
            if (!bus_active) begin
               dcnt_next  = 4'd0;
               state_next = ST_WAITINT;
            end else if (dcnt_reg == 4'(DESKEW)) begin
               vec_next   = bus.d_in_h[7:0] & VEC_MASK;
               level_next = level_of(lvl_reg);
               ssyn_next  = 1'b1;
               state_next = ST_SSYN;
            end else begin
               dcnt_next  = dcnt_reg + 4'd1;
            end
         end

         ST_SSYN: begin
            if (!bus.intr_in_h) begin
               ssyn_next  = 1'b0;
               valid_next = 1'b1;
               state_next = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (vec_ack) begin
               valid_next = 1'b0;
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.bg_out_l   = bg_reg;
   assign bus.ssyn_out_h = ssyn_reg;
   assign vec_valid      = valid_reg;
   assign vec_out        = vec_reg;
   assign vec_level      = level_reg;

endmodule

// File: tb/tb_intarb.sv
// tb_intarb: randomized self-checking bench for the intarb interrupt arbiter.
module tb_intarb;

   localparam int DESKEW  = 4;
   localparam int TIMEOUT = 16;

   logic       CLOCK     = 1'b0;
   logic       RESET     = 1'b0;
   logic       init_in_h = 1'b0;
   logic [2:0] cpu_pri   = 3'd0;
   logic       cpu_rdy   = 1'b0;
   logic       vec_valid;
   logic [7:0] vec_out;
   logic [2:0] vec_level;
   logic       vec_ack   = 1'b0;

   int checks = 0;
   int errors = 0;

   intarb_if bus();

   intarb #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .init_in_h (init_in_h),
      .cpu_pri   (cpu_pri),
      .cpu_rdy   (cpu_rdy),
      .bus       (bus),
      .vec_valid (vec_valid),
      .vec_out   (vec_out),
      .vec_level (vec_level),
      .vec_ack   (vec_ack)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   // Reference: winning level is the highest requested level above the priority.
   function automatic int exp_level(input logic [3:0] br, input logic [2:0] pri);
      int lvl = -1;
      for (int l = 4; l <= 7; l++) begin
         if (br[l-4] && l > int'(pri)) lvl = l;
      end
      return lvl;
   endfunction

   function automatic logic [3:0] exp_bg(input int lvl);
      logic [3:0] bg = 4'b1111;
      if (lvl >= 4) bg[lvl-4] = 1'b0;
      return bg;
   endfunction

   // Device side of one interrupt, starting with the grant for lvl already low.
   task automatic serve_grant(input int lvl, input logic [15:0] d, input int glitch);
      int n;
      logic [7:0] want_vec;
      want_vec = {d[7:2], 2'b00};
      bus.sack_in_h = 1'b1;
      bus.br_in_h[lvl-4] = 1'b0;
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL sack_release: bg_out_l=%b want 1111", bus.bg_out_l);
      end
      bus.sack_in_h = 1'b0;
      bus.bbsy_in_h = 1'b1;
      bus.d_in_h    = d;
      if (glitch > 0) begin
         bus.intr_in_h = 1'b1;
         tick(glitch);
         bus.intr_in_h = 1'b0;
         tick(3);
         checks++;
         if (bus.ssyn_out_h !== 1'b0 || vec_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: ssyn=%b valid=%b want 0 0 (glitch %0d)",
                     bus.ssyn_out_h, vec_valid, glitch);
         end
      end
      bus.intr_in_h = 1'b1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (bus.ssyn_out_h !== 1'b1 && n < 60);
      checks++;
      if (n != DESKEW + 2) begin
         errors++;
         $display("FAIL deskew_latency: ssyn after %0d edges want %0d", n, DESKEW + 2);
      end
      checks++;
      if (vec_out !== want_vec || vec_level !== 3'(lvl) || vec_valid !== 1'b0) begin
         errors++;
         $display("FAIL vector_latch: vec=%o level=%0d valid=%b want vec=%o level=%0d valid=0",
                  vec_out, vec_level, vec_valid, want_vec, lvl);
      end
      tick($urandom_range(1, 4));
      checks++;
      if (bus.ssyn_out_h !== 1'b1 || vec_valid !== 1'b0) begin
         errors++;
         $display("FAIL ssyn_hold: ssyn=%b valid=%b want 1 0", bus.ssyn_out_h, vec_valid);
      end
      bus.intr_in_h = 1'b0;
      bus.bbsy_in_h = 1'b0;
      bus.d_in_h    = 16'h0000;
      tick(1);
      checks++;
      if (bus.ssyn_out_h !== 1'b0 || vec_valid !== 1'b1 || vec_out !== want_vec) begin
         errors++;
         $display("FAIL intr_release: ssyn=%b valid=%b vec=%o want 0 1 %o",
                  bus.ssyn_out_h, vec_valid, vec_out, want_vec);
      end
      tick($urandom_range(1, 3));
      checks++;
      if (vec_valid !== 1'b1 || bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL hold_no_grant: valid=%b bg_out_l=%b want 1 1111", vec_valid, bus.bg_out_l);
      end
      vec_ack = 1'b1;
      tick(1);
      vec_ack = 1'b0;
      checks++;
      if (vec_valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear: valid=%b want 0", vec_valid);
      end
      $display("txn level=%0d vec=%03o deskew_edges=%0d glitch=%0d", lvl, want_vec, n, glitch);
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      cpu_rdy = 1'b1;
      bus.br_in_h = 4'b1111;
      tick(3);
      checks++;
      if (bus.bg_out_l !== 4'b1111 || bus.ssyn_out_h !== 1'b0 || vec_valid !== 1'b0 ||
          vec_out !== 8'h00 || vec_level !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: bg=%b ssyn=%b valid=%b vec=%h level=%0d want 1111 0 0 00 0",
                  bus.bg_out_l, bus.ssyn_out_h, vec_valid, vec_out, vec_level);
      end
      bus.br_in_h = 4'b0000;
      cpu_rdy = 1'b0;
      RESET = 1'b1;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL reset_idle: bg_out_l=%b want 1111", bus.bg_out_l);
      end
   endtask

   task automatic test_basic();
      cpu_pri = 3'd3;
      cpu_rdy = 1'b1;
      bus.br_in_h = 4'b0010;
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL grant_early: bg_out_l=%b want 1111 one edge after pin", bus.bg_out_l);
      end
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1101) begin
         errors++;
         $display("FAIL grant_br5: bg_out_l=%b want 1101", bus.bg_out_l);
      end
      serve_grant(5, 16'o000064, 0);
      checks++;
      if (vec_out !== 8'o064 || vec_level !== 3'd5) begin
         errors++;
         $display("FAIL basic_vector: vec=%o level=%0d want 064 5", vec_out, vec_level);
      end
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL basic_idle: bg_out_l=%b want 1111", bus.bg_out_l);
      end
   endtask

   task automatic test_simultaneous();
      cpu_pri = 3'd0;
      bus.br_in_h = 4'b0101;
      tick(2);
      checks++;
      if (bus.bg_out_l !== exp_bg(exp_level(4'b0101, 3'd0))) begin
         errors++;
         $display("FAIL simul_bg6: bg_out_l=%b want %b", bus.bg_out_l, exp_bg(6));
      end
      serve_grant(6, 16'($urandom), 0);
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1110) begin
         errors++;
         $display("FAIL simul_bg4: bg_out_l=%b want 1110", bus.bg_out_l);
      end
      serve_grant(4, 16'($urandom), 0);
      tick(1);
   endtask

   task automatic test_priority_mask();
      int bad = 0;
      cpu_pri = 3'd5;
      bus.br_in_h = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (bus.bg_out_l !== 4'b1111) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pri_mask: %0d cycles with grant, want 0 (bg=%b)", bad, bus.bg_out_l);
      end
      cpu_pri = 3'd4;
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1101) begin
         errors++;
         $display("FAIL pri_lowered: bg_out_l=%b want 1101", bus.bg_out_l);
      end
      cpu_pri = 3'd7;
      tick(3);
      checks++;
      if (bus.bg_out_l !== 4'b1101) begin
         errors++;
         $display("FAIL pri_no_revoke: bg_out_l=%b want 1101", bus.bg_out_l);
      end
      serve_grant(5, 16'($urandom), 0);
      cpu_pri = 3'd0;
      tick(1);
   endtask

   task automatic test_br_drop();
      cpu_pri = 3'd0;
      bus.br_in_h = 4'b1000;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b0111) begin
         errors++;
         $display("FAIL drop_grant: bg_out_l=%b want 0111", bus.bg_out_l);
      end
      bus.br_in_h = 4'b0000;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1111 || vec_valid !== 1'b0 || bus.ssyn_out_h !== 1'b0) begin
         errors++;
         $display("FAIL drop_release: bg=%b valid=%b ssyn=%b want 1111 0 0",
                  bus.bg_out_l, vec_valid, bus.ssyn_out_h);
      end
      tick(3);
      checks++;
      if (bus.bg_out_l !== 4'b1111 || vec_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_idle: bg=%b valid=%b want 1111 0", bus.bg_out_l, vec_valid);
      end
   endtask

   task automatic test_glitch();
      cpu_pri = 3'd0;
      bus.br_in_h = 4'b0001;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1110) begin
         errors++;
         $display("FAIL glitch_grant: bg_out_l=%b want 1110", bus.bg_out_l);
      end
      serve_grant(4, 16'($urandom), $urandom_range(1, DESKEW - 1));
      tick(1);
   endtask

   task automatic test_random();
      logic [3:0] pending;
      logic [2:0] pri;
      int lvl;
      for (int t = 0; t < 6; t++) begin
         pending = 4'($urandom_range(1, 15));
         pri = 3'($urandom_range(0, 7));
         cpu_pri = pri;
         bus.br_in_h = pending;
         tick(2);
         lvl = exp_level(pending, pri);
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.bg_out_l !== exp_bg(lvl)) begin
               errors++;
               $display("FAIL random_grant: br=%b pri=%0d bg=%b want %b",
                        pending, pri, bus.bg_out_l, exp_bg(lvl));
            end
            if (lvl < 0) break;
            serve_grant(lvl, 16'($urandom), $urandom_range(0, DESKEW - 1));
            pending[lvl-4] = 1'b0;
            lvl = exp_level(pending, pri);
            tick(1);
         end
         bus.br_in_h = 4'b0000;
         tick(2);
      end
      cpu_pri = 3'd0;
   endtask

   task automatic test_timeout();
      int n;
      cpu_pri = 3'd0;
      cpu_rdy = 1'b1;
      bus.br_in_h = 4'b0010;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1101) begin
         errors++;
         $display("FAIL to_grant: bg_out_l=%b want 1101", bus.bg_out_l);
      end
`ifdef INTARB_TIMEOUT_EN
      cpu_rdy = 1'b0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (bus.bg_out_l !== 4'b1111 && n < 100);
      checks++;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL to_release: grant low %0d cycles want %0d", n, TIMEOUT);
      end
      tick(3);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL to_wait_rdy: bg_out_l=%b want 1111", bus.bg_out_l);
      end
      cpu_rdy = 1'b1;
      tick(1);
      checks++;
      if (bus.bg_out_l !== 4'b1101) begin
         errors++;
         $display("FAIL to_regrant: bg_out_l=%b want 1101", bus.bg_out_l);
      end
`else
      n = 0;
      for (int i = 0; i < 3 * TIMEOUT; i++) begin
         tick(1);
         if (bus.bg_out_l !== 4'b1101) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL no_timeout: grant missing %0d cycles want 0", n);
      end
`endif
      bus.br_in_h = 4'b0000;
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL to_drop: bg_out_l=%b want 1111", bus.bg_out_l);
      end
   endtask

   task automatic test_init();
      int n;
      cpu_pri = 3'd0;
      cpu_rdy = 1'b1;
      bus.br_in_h = 4'b0100;
      tick(2);
      init_in_h = 1'b1;
      tick(1);
      init_in_h = 1'b0;
      checks++;
      if (bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL init_grant: bg_out_l=%b want 1111", bus.bg_out_l);
      end
      tick(2);
      checks++;
      if (bus.bg_out_l !== 4'b1011) begin
         errors++;
         $display("FAIL init_regrant: bg_out_l=%b want 1011", bus.bg_out_l);
      end
      bus.sack_in_h = 1'b1;
      bus.br_in_h = 4'b0000;
      tick(1);
      bus.sack_in_h = 1'b0;
      bus.bbsy_in_h = 1'b1;
      bus.intr_in_h = 1'b1;
      bus.d_in_h    = 16'($urandom) | 16'h00F0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (bus.ssyn_out_h !== 1'b1 && n < 60);
      checks++;
      if (bus.ssyn_out_h !== 1'b1) begin
         errors++;
         $display("FAIL init_reach_ssyn: ssyn=%b after %0d cycles want 1", bus.ssyn_out_h, n);
      end
      init_in_h = 1'b1;
      tick(1);
      init_in_h = 1'b0;
      checks++;
      if (bus.ssyn_out_h !== 1'b0 || vec_valid !== 1'b0 || vec_out !== 8'h00 ||
          vec_level !== 3'd0 || bus.bg_out_l !== 4'b1111) begin
         errors++;
         $display("FAIL init_abort: ssyn=%b valid=%b vec=%h level=%0d bg=%b want 0 0 00 0 1111",
                  bus.ssyn_out_h, vec_valid, vec_out, vec_level, bus.bg_out_l);
      end
      bus.intr_in_h = 1'b0;
      bus.bbsy_in_h = 1'b0;
      bus.d_in_h    = 16'h0000;
      tick(3);
      checks++;
      if (vec_valid !== 1'b0 || bus.ssyn_out_h !== 1'b0) begin
         errors++;
         $display("FAIL init_discard: valid=%b ssyn=%b want 0 0", vec_valid, bus.ssyn_out_h);
      end
   endtask

   initial begin
      bus.br_in_h   = 4'b0000;
      bus.sack_in_h = 1'b0;
      bus.bbsy_in_h = 1'b0;
      bus.intr_in_h = 1'b0;
      bus.d_in_h    = 16'h0000;
      test_reset();
      test_basic();
      test_simultaneous();
      test_priority_mask();
      test_br_drop();
      test_glitch();
      test_random();
      test_timeout();
      test_init();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
